// File: rtl/camera_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | camera_pkg                                                           |
// | Shared widths, FSM states and RGB565 packing for the Bayer binner.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package camera_pkg;

    localparam int RAW_W     = 12;
    localparam int R5_W      = 5;
    localparam int G6_W      = 6;
    localparam int B5_W      = 5;
    localparam int RGB565_W  = R5_W + G6_W + B5_W;
    localparam int LB_DATA_W = 2 * RAW_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LINE_WAIT = 2'd1,
        IN_LINE   = 2'd2
    } state_t;

    // Truncating bin of one quad: the two greens are summed at 13 bits.
    function automatic logic [RGB565_W-1:0] pack_rgb565(
        input logic [RAW_W-1:0] r,
        input logic [RAW_W-1:0] g1,
        input logic [RAW_W-1:0] g2,
        input logic [RAW_W-1:0] b
    );
        logic [RAW_W:0] g_sum;
        g_sum = {1'b0, g1} + {1'b0, g2};
        return {r[RAW_W-1 -: R5_W], g_sum[RAW_W -: G6_W], b[RAW_W-1 -: B5_W]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_sdp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | line_buffer_sdp                                                      |
// | Simple dual-port RAM, one write port and one registered read port.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module line_buffer_sdp #(
    parameter int DEPTH  = 320,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // No reset on storage or read register so the array maps to block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/camera_bayer_binner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | camera_bayer_binner                                                  |
// | Bins each 2x2 GRBG Bayer quad of 12-bit raw pixels into one RGB565.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module camera_bayer_binner
    import camera_pkg::*;
#(
    parameter int LINE_WIDTH = 640,
    parameter int ADDR_W     = 9
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                pix_valid,
    input  logic [RAW_W-1:0]    pix_data,
    input  logic                lval,
    input  logic                fval,
    output logic                out_valid,
    output logic [RGB565_W-1:0] out_data,
    output logic                out_sof,
    output logic                out_eol,
    output logic                line_overrun
);

    localparam int              COL_W      = $clog2(LINE_WIDTH + 1);
    localparam logic [COL_W-1:0] c_col_max  = COL_W'(LINE_WIDTH);
    localparam logic [COL_W-1:0] c_col_last = COL_W'(LINE_WIDTH - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_fval_d;
    logic                   r_row_odd;
    logic [COL_W-1:0]       r_col;
    logic                   r_sof_pend;
    logic [RAW_W-1:0]       r_g1;
    logic [RAW_W-1:0]       r_b;
    logic [LB_DATA_W-1:0]   w_rd_data;

    logic w_fval_rise, w_frame_start, w_in_line, w_accept, w_overflow;
    logic w_wr_en, w_rd_en, w_emit, w_line_end;
    logic [ADDR_W-1:0] w_lb_addr;

    assign w_fval_rise   = fval && !r_fval_d;
    assign w_frame_start = (r_state == IDLE) && w_fval_rise && enable;
    assign w_in_line     = (r_state == IN_LINE);
    assign w_accept      = w_in_line && pix_valid && (r_col != c_col_max);
    assign w_overflow    = w_in_line && pix_valid && (r_col == c_col_max);
    assign w_wr_en       = w_accept && !r_row_odd &&  r_col[0];
    assign w_rd_en       = w_accept &&  r_row_odd && !r_col[0];
    assign w_emit        = w_accept &&  r_row_odd &&  r_col[0];
    assign w_line_end    = w_in_line && fval && !lval;
    assign w_lb_addr     = ADDR_W'(r_col >> 1);

    line_buffer_sdp #(
        .DEPTH  (LINE_WIDTH / 2),
        .ADDR_W (ADDR_W),
        .DATA_W (LB_DATA_W)
    ) u_line_buffer (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_lb_addr),
        .i_wr_data ({pix_data, r_g1}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_lb_addr),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:      if (w_fval_rise && enable) w_next_state = LINE_WAIT;
            LINE_WAIT: if (!fval) w_next_state = IDLE;
                       else if (lval) w_next_state = IN_LINE;
            IN_LINE:   if (!fval) w_next_state = IDLE;
                       else if (!lval) w_next_state = LINE_WAIT;
            default:   w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_fval_d resets high so a frame already in progress at reset release
    // is not mistaken for a fresh frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fval_d     <= 1'b1;
            r_row_odd    <= 1'b0;
            r_col        <= '0;
            r_sof_pend   <= 1'b0;
            r_g1         <= '0;
            r_b          <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sof      <= 1'b0;
            out_eol      <= 1'b0;
            line_overrun <= 1'b0;
        end else begin
            r_fval_d  <= fval;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            if (w_frame_start) begin
                r_row_odd    <= 1'b0;
                r_col        <= '0;
                r_sof_pend   <= 1'b1;
                line_overrun <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_col <= r_col + 1'b1;
                    if (!r_col[0]) begin
                        if (r_row_odd) r_b  <= pix_data;
                        else           r_g1 <= pix_data;
                    end
                end
                if (w_overflow) begin
                    line_overrun <= 1'b1;
                end
                if (w_emit) begin
                    out_valid  <= 1'b1;
                    out_data   <= pack_rgb565(w_rd_data[LB_DATA_W-1 -: RAW_W],
                                              w_rd_data[RAW_W-1:0], pix_data, r_b);
                    out_sof    <= r_sof_pend;
                    out_eol    <= (r_col == c_col_last);
                    r_sof_pend <= 1'b0;
                end
                // Placed last so a pixel arriving with lval low still counts
                // but the column restarts for the next line.
                if (w_line_end) begin
                    r_row_odd <= ~r_row_odd;
                    r_col     <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_camera_bayer_binner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_camera_bayer_binner                                               |
// | Randomised bench for the Bayer binner against a quad-level model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_camera_bayer_binner;

    localparam int LW = 8;
    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        reset_n, enable, pix_valid, lval, fval;
    logic [11:0] pix_data;
    logic        out_valid, out_sof, out_eol, line_overrun;
    logic [15:0] out_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eol;
    } px_t;

    px_t         got_q[$];
    px_t         exp_q[$];
    logic [11:0] pix [0:7][0:15];
    int          row_len [0:7];

    camera_bayer_binner #(.LINE_WIDTH(LW), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pix_valid(pix_valid),
        .pix_data(pix_data), .lval(lval), .fval(fval), .out_valid(out_valid),
        .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
        .line_overrun(line_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        px_t p;
        if (out_valid === 1'b1) begin
            p.data = out_data;
            p.sof  = out_sof;
            p.eol  = out_eol;
            got_q.push_back(p);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_random(input int nrows);
        for (int r = 0; r < nrows; r++) begin
            row_len[r] = LW;
            for (int c = 0; c < 16; c++) pix[r][c] = 12'($urandom);
        end
    endtask

    // Reference: one output per complete 2x2 quad of each row pair.
    task automatic build_expected(input int nrows);
        bit first = 1'b1;
        exp_q.delete();
        for (int p = 0; p + 1 < nrows; p += 2) begin
            int ne = (row_len[p]     < LW) ? row_len[p]     : LW;
            int no = (row_len[p + 1] < LW) ? row_len[p + 1] : LW;
            for (int q = 0; 2 * q + 1 < no && 2 * q + 1 < ne; q++) begin
                px_t e;
                int  r5, g6, b5;
                r5 = int'(pix[p][2*q+1]) / 128;
                g6 = (int'(pix[p][2*q]) + int'(pix[p+1][2*q+1])) / 128;
                b5 = int'(pix[p+1][2*q]) / 128;
                e.data = 16'(r5 * 2048 + g6 * 32 + b5);
                e.sof  = first;
                e.eol  = (2 * q + 1 == LW - 1);
                first  = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic frame_start(input bit en);
        enable = en;
        fval   = 1'b1;
        tick();
        tick();
    endtask

    task automatic frame_end();
        fval = 1'b0;
        lval = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_line(input int r, input int len, input bit last_falls, input bit abort);
        lval = 1'b1;
        tick();
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                tick();
            end
            pix_valid = 1'b1;
            pix_data  = pix[r][i];
            if (i == len - 1 && last_falls) begin
                lval = 1'b0;
                if (abort) fval = 1'b0;
            end
            tick();
        end
        pix_valid = 1'b0;
        lval      = 1'b0;
        if (abort) fval = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; pix_valid = 1'b0; pix_data = '0;
        lval = 1'b0; fval = 1'b0;
        repeat (2) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", out_data); end
        total++; if (out_sof !== 1'b0) begin bad++; $display("FAIL reset_sof got=%b exp=0", out_sof); end
        total++; if (out_eol !== 1'b0) begin bad++; $display("FAIL reset_eol got=%b exp=0", out_eol); end
        total++; if (line_overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", line_overrun); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_uniform();
        for (int c = 0; c < LW; c++) begin
            pix[0][c] = (c % 2 == 0) ? 12'h800 : 12'hFFF;
            pix[1][c] = (c % 2 == 0) ? 12'h000 : 12'h800;
        end
        row_len[0] = LW; row_len[1] = LW;
        got_q.delete();
        frame_start(1'b1);
        send_line(0, LW, 1'b0, 1'b0);
        send_line(1, LW, 1'b1, 1'b0);
        frame_end();
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL uni_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            total++;
            if (got_q[i] !== {16'hFC00, i == 0, i == 3}) begin
                bad++;
                $display("FAIL uni_px%0d got=%h/%b/%b exp=fc00/%b/%b", i, got_q[i].data,
                         got_q[i].sof, got_q[i].eol, i == 0, i == 3);
            end
        end
    endtask

    task automatic test_arith();
        fill_random(2);
        pix[0][0] = 12'h7FF; pix[0][1] = 12'h080;
        pix[1][0] = 12'hF80; pix[1][1] = 12'h001;
        build_expected(2);
        got_q.delete();
        frame_start(1'b1);
        send_line(0, LW, 1'b0, 1'b0);
        send_line(1, LW, 1'b0, 1'b0);
        frame_end();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL arith_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        if (got_q.size() > 0) begin
            total++; if (got_q[0].data !== 16'h0A1F) begin bad++; $display("FAIL arith_first got=%h exp=0a1f", got_q[0].data); end
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL arith_px%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back_frame();
        int sofs = 0;
        fill_random(4);
        build_expected(4);
        got_q.delete();
        frame_start(1'b1);
        for (int r = 0; r < 4; r++) send_line(r, LW, 1'($urandom_range(0, 1)), 1'b0);
        frame_end();
        total++; if (got_q.size() != 8) begin bad++; $display("FAIL frame4_count got=%0d exp=8", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL frame4_px%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
            sofs += int'(got_q[i].sof);
        end
        total++; if (sofs != 1) begin bad++; $display("FAIL frame4_sofs got=%0d exp=1", sofs); end
    endtask

    task automatic test_overrun();
        fill_random(2);
        row_len[0] = 10;
        build_expected(2);
        got_q.delete();
        frame_start(1'b1);
        send_line(0, 10, 1'b0, 1'b0);
        total++; if (line_overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", line_overrun); end
        send_line(1, LW, 1'b0, 1'b0);
        frame_end();
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL ovr_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovr_px%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (line_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", line_overrun); end
        frame_start(1'b1);
        total++; if (line_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", line_overrun); end
        frame_end();
    endtask

    task automatic test_enable();
        fill_random(2);
        got_q.delete();
        frame_start(1'b0);
        enable = 1'b1;
        send_line(0, LW, 1'b0, 1'b0);
        send_line(1, LW, 1'b0, 1'b0);
        frame_end();
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL en_drop got=%0d exp=0", got_q.size()); end
        fill_random(2);
        build_expected(2);
        got_q.delete();
        frame_start(1'b1);
        send_line(0, LW, 1'b0, 1'b0);
        send_line(1, LW, 1'b0, 1'b0);
        frame_end();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL en_resume got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL en_px%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        fill_random(4);
        frame_start(1'b1);
        send_line(0, LW, 1'b0, 1'b0);
        lval = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1; pix_data = pix[1][i];
            tick();
        end
        pix_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 16'h0) begin bad++; $display("FAIL rstmid_data got=%h exp=0000", out_data); end
        total++; if ({out_sof, out_eol, line_overrun} !== 3'b000) begin bad++; $display("FAIL rstmid_flags got=%b exp=000", {out_sof, out_eol, line_overrun}); end
        tick();
        reset_n = 1'b1;
        got_q.delete();
        for (int i = 3; i < LW; i++) begin
            pix_valid = 1'b1; pix_data = pix[1][i];
            tick();
        end
        pix_valid = 1'b0; lval = 1'b0;
        tick(); tick();
        send_line(2, LW, 1'b0, 1'b0);
        send_line(3, LW, 1'b0, 1'b0);
        frame_end();
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rstmid_quiet got=%0d exp=0", got_q.size()); end
        build_expected(2);
        got_q.delete();
        frame_start(1'b1);
        send_line(0, LW, 1'b0, 1'b0);
        send_line(1, LW, 1'b0, 1'b0);
        frame_end();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rstmid_resume got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_px%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        fill_random(2);
        row_len[1] = 4;
        build_expected(2);
        got_q.delete();
        frame_start(1'b1);
        send_line(0, LW, 1'b0, 1'b0);
        send_line(1, 4, 1'b1, 1'b1);
        frame_end();
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL abort_count got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_px%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        fill_random(2);
        build_expected(2);
        got_q.delete();
        frame_start(1'b1);
        send_line(0, LW, 1'b0, 1'b0);
        send_line(1, LW, 1'b0, 1'b0);
        frame_end();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL abort_next got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_next_px%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_arith();
        test_back_to_back_frame();
        test_overrun();
        test_enable();
        test_reset_mid();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
